// File: rtl/axi_slv_mem.sv
// axi_slv_mem: AXI4 slave memory with one outstanding write and one outstanding read, independent paths.
// Optional WRAP burst support is compiled in when AXI_SLV_MEM_WRAP_EN is defined.
module axi_slv_mem #(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic [2:0]          AWPROT,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ID_W-1:0]     WID,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [7:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic [2:0]          ARPROT,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));
`ifdef AXI_SLV_MEM_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    // Whole-burst error: oversize transfer, reserved burst, or an illegal/unsupported WRAP.
    function automatic logic burst_err(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_W-1:0] size_mask;
        logic              len_ok;
        logic              size_err;
        logic              err;
        size_mask = (ADDR_W'(1) << size) - ADDR_W'(1);
        len_ok    = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        size_err  = (size > MAX_SIZE);
        case (burst)
            2'b00, 2'b01: err = size_err;
            2'b10:        err = size_err | ~WRAP_EN | ~len_ok | (|(addr & size_mask));
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                                    input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_W-1:0] incr;
        logic [ADDR_W-1:0] wrap_mask;
        logic [ADDR_W-1:0] res;
        incr      = addr + (ADDR_W'(1) << size);
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            2'b01:   res = incr;
            2'b10:   res = WRAP_EN ? ((addr & ~wrap_mask) | (incr & wrap_mask)) : addr;
            default: res = addr;
        endcase
        return res;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr >> MAX_SIZE) < ADDR_W'(MEM_DEPTH);
    endfunction

    logic [DATA_W-1:0] mem_r [MEM_DEPTH];

    w_state_t          w_state_r, w_next_s;
    logic              awready_r, wready_r, bvalid_r;
    logic [ID_W-1:0]   aw_id_r, bid_r;
    logic [ADDR_W-1:0] w_addr_r;
    logic [7:0]        aw_len_r;
    logic [2:0]        aw_size_r;
    logic [1:0]        aw_burst_r, bresp_r;
    logic [8:0]        w_beat_r;
    logic              w_err_r, w_berr_r;
    logic              aw_hs_s, w_hs_s, b_hs_s, w_beat_err_s, w_last_err_s, mem_we_s;
    logic [IDX_W-1:0]  w_idx_s;
    logic [DATA_W-1:0] old_word_s, wr_word_s;

    r_state_t          r_state_r, r_next_s;
    logic              arready_r, rvalid_r, rlast_r;
    logic [ID_W-1:0]   rid_r;
    logic [ADDR_W-1:0] r_addr_r, rd_addr_s;
    logic [7:0]        ar_len_r, r_beat_r;
    logic [2:0]        ar_size_r;
    logic [1:0]        ar_burst_r, rresp_r;
    logic              r_berr_r, rd_berr_s, rd_err_s, ar_hs_s, r_hs_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [DATA_W-1:0] rdata_r, rd_word_s;

    logic unused_s;
    assign unused_s = ^{WID, AWPROT, ARPROT};

    assign aw_hs_s      = AWVALID & awready_r;
    assign w_hs_s       = WVALID & wready_r;
    assign b_hs_s       = BREADY & bvalid_r;
    assign w_beat_err_s = w_berr_r | ~in_range(w_addr_r) | (w_beat_r > {1'b0, aw_len_r});
    assign w_last_err_s = WLAST & (w_beat_r != {1'b0, aw_len_r});
    assign mem_we_s     = w_hs_s & ~w_beat_err_s;
    assign w_idx_s      = IDX_W'(w_addr_r >> MAX_SIZE);
    assign old_word_s   = mem_r[w_idx_s];

    // Merge strobed byte lanes of the write beat into the currently stored word.
    always_comb begin
        wr_word_s = '0;
        for (int i = 0; i < STRB_W; i++) begin
            wr_word_s[8*i +: 8] = WSTRB[i] ? WDATA[8*i +: 8] : old_word_s[8*i +: 8];
        end
    end

    // Storage write port; contents are intentionally not reset.
    always_ff @(posedge ACLK) begin
        if (mem_we_s) begin
            mem_r[w_idx_s] <= wr_word_s;
        end
    end

    // Write FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) w_state_r <= W_IDLE;
        else          w_state_r <= w_next_s;
    end

    // Write FSM next-state logic.
    always_comb begin
        w_next_s = w_state_r;
        case (w_state_r)
            W_IDLE:  if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
            W_DATA:  if (w_hs_s && WLAST) w_next_s = W_RESP; else w_next_s = W_DATA;
            W_RESP:  if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
            default: w_next_s = W_IDLE;
        endcase
    end

    // Write channel handshakes, burst tracking and registered B response.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            aw_id_r    <= '0;
            bid_r      <= '0;
            bresp_r    <= 2'b00;
            w_addr_r   <= '0;
            aw_len_r   <= 8'd0;
            aw_size_r  <= 3'd0;
            aw_burst_r <= 2'b00;
            w_beat_r   <= 9'd0;
            w_err_r    <= 1'b0;
            w_berr_r   <= 1'b0;
        end else begin
            awready_r <= (w_next_s == W_IDLE);
            wready_r  <= (w_next_s == W_DATA);
            bvalid_r  <= (w_next_s == W_RESP);
            if (aw_hs_s) begin
                aw_id_r    <= AWID;
                w_addr_r   <= AWADDR;
                aw_len_r   <= AWLEN;
                aw_size_r  <= AWSIZE;
                aw_burst_r <= AWBURST;
                w_beat_r   <= 9'd0;
                w_err_r    <= 1'b0;
                w_berr_r   <= burst_err(AWADDR, AWLEN, AWSIZE, AWBURST);
            end else if (w_hs_s) begin
                w_addr_r <= next_addr(w_addr_r, aw_len_r, aw_size_r, aw_burst_r);
                // Saturate so over-long bursts never alias back into the legal beat range.
                if (!w_beat_r[8]) w_beat_r <= w_beat_r + 9'd1;
                w_err_r <= w_err_r | w_beat_err_s | w_last_err_s;
                if (WLAST) begin
                    bid_r   <= aw_id_r;
                    bresp_r <= (w_err_r | w_beat_err_s | w_last_err_s) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    assign ar_hs_s   = ARVALID & arready_r;
    assign r_hs_s    = RREADY & rvalid_r;
    assign rd_addr_s = ar_hs_s ? ARADDR : next_addr(r_addr_r, ar_len_r, ar_size_r, ar_burst_r);
    assign rd_berr_s = ar_hs_s ? burst_err(ARADDR, ARLEN, ARSIZE, ARBURST) : r_berr_r;
    assign rd_err_s  = rd_berr_s | ~in_range(rd_addr_s);
    assign rd_idx_s  = IDX_W'(rd_addr_s >> MAX_SIZE);
    assign rd_word_s = mem_r[rd_idx_s];

    // Read FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state_r <= R_IDLE;
        else          r_state_r <= r_next_s;
    end

    // Read FSM next-state logic.
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE:  if (ar_hs_s) r_next_s = R_DATA; else r_next_s = R_IDLE;
            R_DATA:  if (r_hs_s && rlast_r) r_next_s = R_IDLE; else r_next_s = R_DATA;
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read channel: register each beat ahead of the handshake that consumes it.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            rid_r      <= '0;
            rdata_r    <= '0;
            rresp_r    <= 2'b00;
            r_addr_r   <= '0;
            ar_len_r   <= 8'd0;
            ar_size_r  <= 3'd0;
            ar_burst_r <= 2'b00;
            r_beat_r   <= 8'd0;
            r_berr_r   <= 1'b0;
        end else begin
            arready_r <= (r_next_s == R_IDLE);
            rvalid_r  <= (r_next_s == R_DATA);
            if (ar_hs_s) begin
                rid_r      <= ARID;
                ar_len_r   <= ARLEN;
                ar_size_r  <= ARSIZE;
                ar_burst_r <= ARBURST;
                r_berr_r   <= rd_berr_s;
                r_addr_r   <= rd_addr_s;
                r_beat_r   <= 8'd0;
                rdata_r    <= rd_err_s ? '0 : rd_word_s;
                rresp_r    <= rd_err_s ? 2'b10 : 2'b00;
                rlast_r    <= (ARLEN == 8'd0);
            end else if (r_hs_s && !rlast_r) begin
                r_addr_r <= rd_addr_s;
                r_beat_r <= r_beat_r + 8'd1;
                rdata_r  <= rd_err_s ? '0 : rd_word_s;
                rresp_r  <= rd_err_s ? 2'b10 : 2'b00;
                rlast_r  <= ((r_beat_r + 8'd1) == ar_len_r);
            end else if (r_hs_s) begin
                rlast_r <= 1'b0;
            end
        end
    end

    assign AWREADY = awready_r;
    assign WREADY  = wready_r;
    assign BVALID  = bvalid_r;
    assign BID     = bid_r;
    assign BRESP   = bresp_r;
    assign ARREADY = arready_r;
    assign RVALID  = rvalid_r;
    assign RID     = rid_r;
    assign RDATA   = rdata_r;
    assign RRESP   = rresp_r;
    assign RLAST   = rlast_r;
endmodule

// File: doc/axi_slv_mem.md
# axi_slv_mem

- AXI4 slave memory with a word-organised internal storage array; it is the responder on the slave side of the AXI interface.
- Terminates all five channels and serves as the default DUT-side endpoint for master-agent bring-up.
- Handles one outstanding write and one outstanding read. The read and write paths run independently and concurrently.

## Interface

- ID_W, 4, width of AWID/WID/BID/ARID/RID
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width in bits (power of two, ≥ 8)
- MEM_DEPTH, 1024, number of DATA_W words

Ports:

- ACLK  in  1  clock; all logic is on the rising edge
- ARESETn  in  1  asynchronous active-low reset
- AWID/AWADDR/AWLEN[7:0]/AWSIZE[2:0]/AWBURST[1:0]/AWPROT[2:0]/AWVALID  in  write-address channel
- AWREADY  out  1
- WID/WDATA/WSTRB[DATA_W/8]/WLAST/WVALID  in  write-data channel
  - WID and AWPROT/ARPROT are ignored.
- WREADY  out  1
- BID  out  ID_W
- BRESP  out  2
- BVALID  out  1
- BREADY  in  1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARPROT/ARVALID  in  read-address channel
- ARREADY  out  1
- RID  out  ID_W
- RDATA  out  DATA_W
- RRESP  out  2
- RLAST  out  1
- RVALID  out  1
- RREADY  in  1

## Operation

Write FSM, states W_IDLE → W_DATA → W_RESP → W_IDLE:

- **W_IDLE:** AWREADY=1. On an AW handshake, latch ID, address, LEN, SIZE and BURST; clear the beat counter and the error flag; go to W_DATA.
- **W_DATA:** WREADY=1. On each W handshake:
  - Bytes with WSTRB set are written to word addr>>log2(DATA_W/8). No other bytes change.
  - Then advance the address and the beat counter.
  - On the WLAST beat, go to W_RESP.
- **W_RESP:** BVALID=1 and BID=latched AWID. BRESP is 2'b10 (SLVERR) if the error flag is set, else 2'b00. Hold until BREADY; then go to W_IDLE.

Read FSM, states R_IDLE → R_DATA → R_IDLE:

- **R_IDLE:** ARREADY=1. On an AR handshake, latch the request and register beat 0 onto RDATA/RRESP/RLAST; go to R_DATA.
- **R_DATA:** RVALID=1 and RID=latched ARID. RLAST=1 when beat == ARLEN.
  - On an R handshake that is not the last beat, register the next beat.
  - On an R handshake on the last beat, go to R_IDLE.

Address rules (per beat):

- FIXED (2'b00): the address is unchanged.
- INCR (2'b01): addr += 1<<SIZE, computed ADDR_W-wide and modulo 2^ADDR_W.

Error rules (each sets SLVERR; no write to memory; read data is 0):

- SIZE > log2(DATA_W/8): error for the whole burst.
- Reserved BURST 2'b11: error for the whole burst.
- Word index ≥ MEM_DEPTH: error for that beat only.
- Write beats beyond AWLEN+1 are not written and set the error flag.
- WLAST on a beat other than AWLEN+1 sets the error flag. The burst still ends on WLAST.
- Reads report RRESP per beat.

Other behaviour:

- Storage is not reset; its contents after reset are undefined.
- A write beat and a read beat to the same word in the same cycle: the read returns the old data.

## Timing

- Reset value (ARESETn=0): every output is 0, including all READY and VALID signals.
- AWREADY and ARREADY rise on the first ACLK edge after ARESETn deasserts.
- Reset asserted mid-burst: both FSMs return to idle immediately. Outstanding responses are dropped and outputs go to their reset values.
- AW handshake at edge N: AWREADY=0 and WREADY=1 from N+1. One write beat per cycle.
- WLAST handshake at edge M: WREADY=0 and BVALID=1 from M+1.
- B handshake at edge K: AWREADY=1 from K+1.
- AR handshake at edge N: RVALID=1 with beat 0 from N+1.
- With RREADY held high, beats are back-to-back, one per cycle. The last beat ends the burst at edge N+1+ARLEN.
- ARREADY=1 in the cycle after the last R handshake.
- While RVALID=1 and RREADY=0, RDATA/RRESP/RLAST/RID are held stable.
- While BVALID=1 and BREADY=0, BID/BRESP are held stable.
- AW and W may arrive in the same cycle. A W beat presented before the AW handshake waits, because WREADY=0 in W_IDLE.

## Configuration

Macro `AXI_SLV_MEM_WRAP_EN`:

- **Defined:** WRAP (2'b10) is supported.
  - Legal only for LEN ∈ {1,3,7,15}.
  - Boundary = (LEN+1)<<SIZE. The address wraps to the start of the aligned boundary block.
  - A WRAP burst with an unaligned start address or an illegal LEN is an error for the whole burst.
- **Undefined:** WRAP is treated like the reserved value: the whole burst returns SLVERR and no memory access occurs.

## Test plan

1. Write ID=3, addr 0x10, INCR, LEN=3, SIZE=2, data 0xA0..0xA3, WSTRB=0xF -> BID=3, BRESP=00. Reading the same burst back returns 0xA0..0xA3 with RLAST on beat 3 only.
2. Write 0xFFFFFFFF to 0x40, then 0x11223344 with WSTRB=0x5 -> a read of 0x40 returns 0xFF22FF44.
3. FIXED write LEN=2 to 0x8 with data 1,2,3 -> a read of 0x8 returns 3. A write to 0x1000 (index 1024) -> BRESP=10, and a read there returns RRESP=10 with RDATA=0.
4. INCR read LEN=7 with RREADY toggled 1,0,0,1,... -> RVALID stays high across stalls, data is held stable, RLAST is 1 only on beat 7, and ARREADY=1 the cycle after the final handshake.
5. AWLEN=3 with WLAST asserted on beat 2 -> BRESP=10 and no fourth beat is accepted. Asserting ARESETn=0 mid read burst -> RVALID=0 immediately and ARREADY=1 one cycle after release.
6. WRAP, LEN=3, SIZE=2, addr 0x38: with `AXI_SLV_MEM_WRAP_EN` defined, the beats hit 0x38, 0x3C, 0x30, 0x34. With the macro undefined, BRESP=10.
